// File: rtl/jt900h_idxaddr.sv
// TLCS-900H memory addressing-mode decoder: fetches operand bytes and a base register to form a 24-bit ea.
// Latency: ea_ok N+2 cen cycles after start for register modes, N+1 for immediate modes (N = bytes fetched).
// Backpressure: waits in FETCH until fetch_ok; cen=0 freezes all state. JT900H_IDXADDR_REGIDX_EN adds (r+r8)/(r+r16).
module jt900h_idxaddr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        start,
    input  logic [7:0]  md,
    input  logic [7:0]  fetch_data,
    input  logic        fetch_ok,
    output logic        fetch_req,
    output logic        idx_en,
    output logic [7:0]  idx_rdreg_sel,
    output logic [7:0]  idx_rdreg_aux,
    input  logic [31:0] idx_rdreg,
    output logic [1:0]  reg_step,
    output logic        reg_inc,
    output logic        reg_dec,
    output logic [23:0] ea,
    output logic        ea_ok,
    output logic        err,
    output logic        busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_REG   = 3'd2;
`ifdef JT900H_IDXADDR_REGIDX_EN
    localparam logic [2:0] S_IDX   = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [3:0] M_R     = 4'd0;
    localparam logic [3:0] M_D8    = 4'd1;
    localparam logic [3:0] M_D16   = 4'd2;
    localparam logic [3:0] M_IMM   = 4'd3;
    localparam logic [3:0] M_DEC   = 4'd4;
    localparam logic [3:0] M_INC   = 4'd5;
    localparam logic [3:0] M_EXT   = 4'd6;
`ifdef JT900H_IDXADDR_REGIDX_EN
    localparam logic [3:0] M_IDX8  = 4'd7;
    localparam logic [3:0] M_IDX16 = 4'd8;
`endif

    logic [2:0]  state;
    logic [3:0]  mode;
    logic        rb_phase;
    logic [1:0]  need;
    logic [1:0]  cnt;
    logic [23:0] dbuf;
    logic [23:0] dbuf_nxt;
    logic [7:0]  base;
    logic [1:0]  step;
    logic [23:0] step_amt;
    logic [23:0] reg_ea;
    logic        unused_bits;

    assign unused_bits = ^{idx_rdreg[31:24], md[5:4]};
    assign step_amt    = 24'd1 << step;

    always_comb begin
        dbuf_nxt = dbuf;
        case (cnt)
            2'd0:    dbuf_nxt[7:0]   = fetch_data;
            2'd1:    dbuf_nxt[15:8]  = fetch_data;
            default: dbuf_nxt[23:16] = fetch_data;
        endcase
    end

    always_comb begin
        reg_ea = idx_rdreg[23:0];
        case (mode)
            M_D8:    reg_ea = idx_rdreg[23:0] + {{16{dbuf[7]}}, dbuf[7:0]};
            M_D16:   reg_ea = idx_rdreg[23:0] + {{8{dbuf[15]}}, dbuf[15:0]};
            M_DEC:   reg_ea = idx_rdreg[23:0] - step_amt;
            default: ;
        endcase
    end

    assign busy      = state != S_IDLE;
    assign fetch_req = state == S_FETCH;
    assign ea_ok     = state == S_DONE;
    assign err       = state == S_ERR;
    assign reg_dec   = (state == S_REG) && (mode == M_DEC);
    assign reg_inc   = (state == S_REG) && (mode == M_INC);
    assign reg_step  = (reg_dec || reg_inc) ? step : 2'd0;

`ifdef JT900H_IDXADDR_REGIDX_EN
    assign idx_en        = (state == S_REG) || (state == S_IDX);
    assign idx_rdreg_sel = (state == S_REG) ? base : (state == S_IDX) ? dbuf[7:0] : 8'd0;
    assign idx_rdreg_aux = (state == S_IDX) ? dbuf[7:0] : 8'd0;
`else
    assign idx_en        = state == S_REG;
    assign idx_rdreg_sel = (state == S_REG) ? base : 8'd0;
    assign idx_rdreg_aux = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode     <= M_R;
            rb_phase <= 1'b0;
            need     <= 2'd0;
            cnt      <= 2'd0;
            dbuf     <= 24'd0;
            base     <= 8'd0;
            step     <= 2'd0;
            ea       <= 24'd0;
        end else if (cen) begin
            case (state)
                S_IDLE: if (start) begin
                    cnt      <= 2'd0;
                    dbuf     <= 24'd0;
                    rb_phase <= 1'b0;
                    need     <= 2'd1;
                    step     <= 2'd0;
                    base     <= {3'b111, md[2:0], 2'b00};
                    if (!md[7]) begin
                        state <= S_ERR;
                    end else if (!md[6]) begin
                        mode  <= md[3] ? M_D8 : M_R;
                        state <= md[3] ? S_FETCH : S_REG;
                    end else begin
                        case (md[2:0])
                            3'd0, 3'd1, 3'd2: begin
                                mode  <= M_IMM;
                                need  <= md[1:0] + 2'd1;
                                state <= S_FETCH;
                            end
                            3'd3, 3'd4, 3'd5: begin
                                mode     <= (md[2:0] == 3'd3) ? M_EXT :
                                            (md[2:0] == 3'd4) ? M_DEC : M_INC;
                                rb_phase <= 1'b1;
                                state    <= S_FETCH;
                            end
                            default: state <= S_ERR;
                        endcase
                    end
                end
                S_FETCH: if (fetch_ok) begin
                    if (rb_phase) begin
                        // register byte: selects the base and refines the mode
                        rb_phase <= 1'b0;
                        base     <= {fetch_data[7:2], 2'b00};
                        if (mode == M_EXT) begin
                            case (fetch_data[1:0])
                                2'b00: begin
                                    mode  <= M_R;
                                    state <= S_REG;
                                end
                                2'b01: begin
                                    mode <= M_D16;
                                    need <= 2'd2;
                                end
`ifdef JT900H_IDXADDR_REGIDX_EN
                                default: mode <= fetch_data[0] ? M_IDX16 : M_IDX8;
`else
                                default: state <= S_ERR;
`endif
                            endcase
                        end else if (fetch_data[1:0] == 2'b11) begin
                            state <= S_ERR;
                        end else begin
                            step  <= fetch_data[1:0];
                            state <= S_REG;
                        end
                    end else begin
                        dbuf <= dbuf_nxt;
                        cnt  <= cnt + 2'd1;
                        if (cnt + 2'd1 == need) begin
                            if (mode == M_IMM) begin
                                ea    <= dbuf_nxt;
                                state <= S_DONE;
                            end else begin
                                state <= S_REG;
                            end
                        end
                    end
                end
                S_REG: begin
                    ea <= reg_ea;
`ifdef JT900H_IDXADDR_REGIDX_EN
                    state <= (mode == M_IDX8 || mode == M_IDX16) ? S_IDX : S_DONE;
`else
                    state <= S_DONE;
`endif
                end
`ifdef JT900H_IDXADDR_REGIDX_EN
                S_IDX: begin
                    ea <= ea + ((mode == M_IDX16) ? {{8{idx_rdreg[15]}}, idx_rdreg[15:0]}
                                                  : {{16{idx_rdreg[7]}}, idx_rdreg[7:0]});
                    state <= S_DONE;
                end
`endif
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jt900h_idxaddr.sv
// Scoreboard bench for jt900h_idxaddr: directed vectors push expected results, a monitor pops on ea_ok/err.
module tb_jt900h_idxaddr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  md = 8'h00;
    logic [7:0]  fetch_data = 8'h00;
    logic        fetch_ok = 1'b0;
    logic        fetch_req, idx_en, reg_inc, reg_dec, ea_ok, err, busy;
    logic [7:0]  idx_rdreg_sel, idx_rdreg_aux;
    logic [31:0] idx_rdreg;
    logic [1:0]  reg_step;
    logic [23:0] ea;

    logic [31:0] rf [0:255];
    assign idx_rdreg = rf[idx_rdreg_sel];

    jt900h_idxaddr dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .md(md),
        .fetch_data(fetch_data), .fetch_ok(fetch_ok), .fetch_req(fetch_req),
        .idx_en(idx_en), .idx_rdreg_sel(idx_rdreg_sel), .idx_rdreg_aux(idx_rdreg_aux),
        .idx_rdreg(idx_rdreg), .reg_step(reg_step), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .ea(ea), .ea_ok(ea_ok), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [23:0] ea;
        int          lat;
        int          t0;
        logic        en;
        logic [7:0]  sel;
        logic [7:0]  aux;
        logic        dec;
        logic        inc;
        logic [1:0]  step;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [23:0] last_ea = 24'd0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic is_err, input logic [23:0] e_ea, input int lat,
                                input logic en, input logic [7:0] sel,
                                input logic dec, input logic inc, input logic [1:0] step);
        exp_t e;
        e.is_err = is_err; e.ea = e_ea; e.lat = lat; e.t0 = 0; e.en = en; e.sel = sel;
        e.aux = 8'h00; e.dec = dec; e.inc = inc; e.step = step;
        return e;
    endfunction

    // monitor: gathers register-port activity per operation, checks it when ea_ok/err appears
    initial begin
        exp_t       e;
        logic       s_en, s_dec, s_inc, s_both;
        logic [7:0] s_sel, s_aux;
        logic [1:0] s_step;
        s_en = 0; s_dec = 0; s_inc = 0; s_both = 0; s_sel = 0; s_aux = 0; s_step = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_en = 0; s_dec = 0; s_inc = 0; s_both = 0; s_sel = 0; s_aux = 0; s_step = 0;
            end else begin
                if (idx_en && !s_en) begin s_en = 1; s_sel = idx_rdreg_sel; end
                s_aux = s_aux | idx_rdreg_aux;
                if (reg_inc && reg_dec) s_both = 1;
                if (reg_dec) s_dec = 1;
                if (reg_inc) s_inc = 1;
                if (reg_dec || reg_inc) s_step = reg_step;
                if (ea_ok || err) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got ea_ok=%0b err=%0b expected none", ea_ok, err);
                    end else begin
                        e = q.pop_front();
                        chk("ok_err", {30'd0, err, ea_ok}, {30'd0, e.is_err, !e.is_err});
                        chk("ea", {8'd0, ea}, {8'd0, e.ea});
                        if (e.lat != 0) chk("latency", cyc - e.t0, e.lat);
                        chk("idx_en_seen", {31'd0, s_en}, {31'd0, e.en});
                        if (e.en) chk("idx_rdreg_sel", {24'd0, s_sel}, {24'd0, e.sel});
                        chk("idx_rdreg_aux", {24'd0, s_aux}, {24'd0, e.aux});
                        chk("dec_inc", {29'd0, s_both, s_dec, s_inc}, {29'd0, 1'b0, e.dec, e.inc});
                        if (e.dec || e.inc) chk("reg_step", {30'd0, s_step}, {30'd0, e.step});
                    end
                    s_en = 0; s_dec = 0; s_inc = 0; s_both = 0; s_sel = 0; s_aux = 0; s_step = 0;
                end
            end
        end
    end

    task automatic run(input logic [7:0] m, input int n, input logic [23:0] b,
                       input logic gap, input exp_t e_in);
        exp_t e;
        int   w;
        e = e_in;
        if (e.is_err) e.ea = last_ea; else last_ea = e.ea;
        e.t0 = cyc;
        q.push_back(e);
        md = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!fetch_req && w < 10) begin @(negedge clk); w++; end
            if (!fetch_req) begin
                errors++;
                $display("FAIL fetch_req_timeout: got 0 expected 1 (md=%0h byte %0d)", m, i);
                break;
            end
            if (gap) begin
                // idle cycle with a stray start that must be ignored while busy
                fetch_ok = 1'b0; start = 1'b1; md = 8'hC7;
                @(negedge clk);
                start = 1'b0; md = 8'h00;
            end
            fetch_ok = 1'b1; fetch_data = b[8*i +: 8];
            @(negedge clk);
        end
        fetch_ok = 1'b0; fetch_data = 8'h00;
        w = 0;
        while (q.size() != 0 && w < 20) begin @(negedge clk); w++; end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got no ea_ok/err expected one (md=%0h)", m);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 256; i++) rf[i] = 32'h0;

        #2;
        chk("rst_ea", {8'd0, ea}, 32'd0);
        chk("rst_strobes", {23'd0, busy, ea_ok, err, fetch_req, idx_en, reg_inc, reg_dec, reg_step},
            32'd0);
        chk("rst_sel_aux", {16'd0, idx_rdreg_sel, idx_rdreg_aux}, 32'd0);
        cen = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rf[8'hE8] = 32'h0012_3456;
        run(8'h82, 0, 24'h0, 0, mk(0, 24'h123456, 2, 1, 8'hE8, 0, 0, 2'd0));
        rf[8'hF0] = 32'h0000_1000;
        run(8'h8C, 1, 24'h0000FE, 0, mk(0, 24'h000FFE, 3, 1, 8'hF0, 0, 0, 2'd0));
        run(8'hC2, 3, 24'h123456, 1, mk(0, 24'h123456, 7, 0, 8'h00, 0, 0, 2'd0));
        rf[8'hF0] = 32'h0000_0200;
        run(8'hC4, 1, 24'h0000F2, 0, mk(0, 24'h0001FC, 3, 1, 8'hF0, 1, 0, 2'd2));
        rf[8'hE0] = 32'h0001_0000;
        run(8'hC3, 3, 24'h8000E1, 0, mk(0, 24'h008000, 5, 1, 8'hE0, 0, 0, 2'd0));
        rf[8'hE4] = 32'hFFAB_CDEF;
        run(8'hC5, 1, 24'h0000E5, 0, mk(0, 24'hABCDEF, 3, 1, 8'hE4, 0, 1, 2'd1));
        run(8'hC0, 1, 24'h00009A, 0, mk(0, 24'h00009A, 2, 0, 8'h00, 0, 0, 2'd0));
        rf[8'hFC] = 32'h00FE_DCBA;
        run(8'hB7, 0, 24'h0, 0, mk(0, 24'hFEDCBA, 2, 1, 8'hFC, 0, 0, 2'd0));
        run(8'h40, 0, 24'h0, 0, mk(1, 24'h0, 0, 0, 8'h00, 0, 0, 2'd0));
        run(8'hC4, 1, 24'h0000E3, 0, mk(1, 24'h0, 0, 0, 8'h00, 0, 0, 2'd0));
`ifdef JT900H_IDXADDR_REGIDX_EN
        rf[8'hE0] = 32'h0000_1000;
        rf[8'hE4] = 32'h0000_00F0;
        e = mk(0, 24'h000FF0, 5, 1, 8'hE0, 0, 0, 2'd0);
        e.aux = 8'hE4;
        run(8'hC3, 2, 24'h00E4E2, 0, e);
`else
        run(8'hC3, 1, 24'h0000E2, 0, mk(1, 24'h0, 0, 0, 8'h00, 0, 0, 2'd0));
`endif
        run(8'hC7, 0, 24'h0, 0, mk(1, 24'h0, 0, 0, 8'h00, 0, 0, 2'd0));

        // reset in the middle of a 16-bit immediate fetch
        md = 8'hC1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md = 8'h00; fetch_ok = 1'b1; fetch_data = 8'h77;
        @(negedge clk);
        fetch_ok = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy_req", {30'd0, busy, fetch_req}, 32'd0);
        chk("arst_ea", {8'd0, ea}, 32'd0);
        chk("arst_incdec", {30'd0, reg_inc, reg_dec}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_ea = 24'd0;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        run(8'hC1, 2, 24'h002211, 0, mk(0, 24'h002211, 3, 0, 8'h00, 0, 0, 2'd0));

        // start with cen low must not be accepted
        cen = 1'b0; md = 8'h82; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md = 8'h00;
        @(negedge clk);
        chk("cen_hold_busy", {31'd0, busy}, 32'd0);
        chk("cen_hold_ea", {8'd0, ea}, 32'h002211);
        cen = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
